// File: rtl/educell_esmunit_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the ESM pairing controller.
// AQMEAS_TH is the ancilla count; the index and count widths derive from it.
package educell_esmunit_ctrl_pkg;

  localparam int AQMEAS_TH = 8;
  localparam int IW        = $clog2(AQMEAS_TH);
  localparam int CW        = $clog2(AQMEAS_TH) + 1;

  // Largest pair count a single vector can produce: ceil(AQMEAS_TH/2).
  localparam logic [CW-1:0] CNT_MAX = CW'((AQMEAS_TH + 1) / 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [AQMEAS_TH-1:0] idx_mask(input logic [IW-1:0] idx);
    idx_mask = {{(AQMEAS_TH-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/educell_esmunit_ctrl_if.sv
// Load / pair / status bundle between the ESM pairing controller and its user.
import educell_esmunit_ctrl_pkg::*;

interface educell_esmunit_ctrl_if;
  logic                 load_valid;
  logic [AQMEAS_TH-1:0] load_esm;
  logic                 load_ready;
  logic                 flush;
  logic                 pair_valid;
  logic                 pair_ready;
  logic [IW-1:0]        pair_first_idx;
  logic [IW-1:0]        pair_second_idx;
  logic                 pair_single;
  logic                 busy;
  logic                 done;
  logic [CW-1:0]        pair_cnt;

  modport master (
    output load_valid, load_esm, flush, pair_ready,
    input  load_ready, pair_valid, pair_first_idx, pair_second_idx,
           pair_single, busy, done, pair_cnt
  );

  modport slave (
    input  load_valid, load_esm, flush, pair_ready,
    output load_ready, pair_valid, pair_first_idx, pair_second_idx,
           pair_single, busy, done, pair_cnt
  );
endinterface

// File: rtl/educell_esmunit_idx.sv
// Finds the lowest and second-lowest set bit of the pending ESM vector.
import educell_esmunit_ctrl_pkg::*;

module educell_esmunit_idx (
  input  logic [AQMEAS_TH-1:0] vec,
  output logic [IW-1:0]        first_idx,
  output logic [IW-1:0]        second_idx,
  output logic                 first_found,
  output logic                 second_found
);

  // Ascending priority scan; second_found doubles as "popcount >= 2".
  always_comb begin
    first_idx    = {IW{1'b0}};
    second_idx   = {IW{1'b0}};
    first_found  = 1'b0;
    second_found = 1'b0;
    for (int i = 0; i < AQMEAS_TH; i++) begin
      if (vec[i]) begin
        if (!first_found) begin
          first_idx   = IW'(i);
          first_found = 1'b1;
        end else if (!second_found) begin
          second_idx   = IW'(i);
          second_found = 1'b1;
        end else begin
          second_found = 1'b1;
        end
      end else begin
        first_found = first_found;
      end
    end
  end

endmodule

// File: rtl/educell_esmunit_ctrl.sv
// ESM pairing controller: drains a flag vector as ascending index pairs,
// with a trailing single matched to the boundary when the count is odd.
import educell_esmunit_ctrl_pkg::*;

module educell_esmunit_ctrl (
  input  logic                   clk,
  input  logic                   rst,
  educell_esmunit_ctrl_if.slave  bus
);

  state_e               state_r, state_next_s;
  logic [AQMEAS_TH-1:0] work_r, work_next_s, cleared_s;
  logic [CW-1:0]        cnt_r, cnt_next_s;
  logic [IW-1:0]        first_r, first_next_s;
  logic [IW-1:0]        second_r, second_next_s;
  logic                 single_r, single_next_s;
  logic                 pair_valid_r, busy_r, done_r, idle_r;
  logic [IW-1:0]        first_s, second_s;
  logic                 first_found_s, second_found_s;

  educell_esmunit_idx u_idx (
    .vec          (work_r),
    .first_idx    (first_s),
    .second_idx   (second_s),
    .first_found  (first_found_s),
    .second_found (second_found_s)
  );

  // Work vector once the currently presented pair (or single) is retired.
  always_comb begin
    cleared_s = work_r & ~idx_mask(first_r);
    if (!single_r) begin
      cleared_s = cleared_s & ~idx_mask(second_r);
    end else begin
      cleared_s = cleared_s;
    end
  end

  // Next-state and next-datapath decode; flush wins over everything but rst.
  always_comb begin
    state_next_s  = state_r;
    work_next_s   = work_r;
    cnt_next_s    = cnt_r;
    first_next_s  = first_r;
    second_next_s = second_r;
    single_next_s = single_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.load_valid && !bus.flush) begin
          work_next_s  = bus.load_esm;
          cnt_next_s   = {CW{1'b0}};
          state_next_s = ST_SCAN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (bus.flush) begin
          work_next_s  = {AQMEAS_TH{1'b0}};
          state_next_s = ST_IDLE;
        end else if (!first_found_s) begin
          state_next_s = ST_DONE;
        end else begin
          first_next_s  = first_s;
          second_next_s = second_found_s ? second_s : {IW{1'b0}};
          single_next_s = !second_found_s;
          state_next_s  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.flush) begin
          work_next_s  = {AQMEAS_TH{1'b0}};
          state_next_s = ST_IDLE;
        end else if (bus.pair_ready) begin
          work_next_s  = cleared_s;
          cnt_next_s   = (cnt_r != CNT_MAX) ? cnt_r + {{(CW-1){1'b0}}, 1'b1} : cnt_r;
          // Skip the re-scan of an empty vector so done follows the last pair directly.
          state_next_s = (cleared_s == {AQMEAS_TH{1'b0}}) ? ST_DONE : ST_SCAN;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_DONE: begin
        work_next_s  = {AQMEAS_TH{1'b0}};
        state_next_s = ST_IDLE;
      end
      default: begin
        work_next_s  = {AQMEAS_TH{1'b0}};
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and registered status outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_r       <= {AQMEAS_TH{1'b0}};
      cnt_r        <= {CW{1'b0}};
      first_r      <= {IW{1'b0}};
      second_r     <= {IW{1'b0}};
      single_r     <= 1'b0;
      pair_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      idle_r       <= 1'b1;
    end else begin
      work_r       <= work_next_s;
      cnt_r        <= cnt_next_s;
      first_r      <= first_next_s;
      second_r     <= second_next_s;
      single_r     <= single_next_s;
      pair_valid_r <= (state_next_s == ST_ISSUE);
      busy_r       <= (state_next_s != ST_IDLE);
      done_r       <= (state_next_s == ST_DONE);
      idle_r       <= (state_next_s == ST_IDLE);
    end
  end

  // Ready is masked by rst so it drops while reset is held and rises right after.
  assign bus.load_ready      = idle_r & ~rst;
  assign bus.pair_valid      = pair_valid_r;
  assign bus.pair_first_idx  = first_r;
  assign bus.pair_second_idx = second_r;
  assign bus.pair_single     = single_r;
  assign bus.busy            = busy_r;
  assign bus.done            = done_r;
  assign bus.pair_cnt        = cnt_r;

endmodule
